// File: rtl/ram_32x32.sv
// rtl/ram_32x32.sv - 32x32 register-based data memory, synchronous write, combinational read
// Flop storage lets the asynchronous reset clear every word.
module ram_32x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (i_we) begin
            mem[i_addr] <= i_data;
        end
    end

    // Read-through of the stored word only; i_data is never bypassed.
    assign o_data = mem[i_addr];

endmodule

// File: tb/tb_ram_32x32.sv
// tb/tb_ram_32x32.sv - self-checking bench for ram_32x32
module tb_ram_32x32;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] ref_mem [32];

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [4];

    ram_32x32 dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_we    (we),
        .i_addr  (addr),
        .i_data  (wdata),
        .o_data  (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    endtask

    initial begin
        rst_n = 1'b1;
        we    = 1'b0;
        addr  = 5'd0;
        wdata = 32'h0;
        clear_model();

        // Reset sweep
        #2 rst_n = 1'b0;
        for (int a = 0; a < 32; a++) begin
            addr = a[4:0];
            #1 check($sformatf("reset_sweep[%0d]", a), rdata, 32'h0);
        end
        // Writes while reset is held are ignored
        we = 1'b1; addr = 5'd4; wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        check("write_in_reset", rdata, 32'h0);
        @(negedge clk);
        we = 1'b0;
        rst_n = 1'b1;

        vecs[0] = '{we: 1'b1, addr: 5'd3,  data: 32'hABBA_DEAD, exp: 32'hABBA_DEAD};
        vecs[1] = '{we: 1'b1, addr: 5'd31, data: 32'hDEAD_BEEF, exp: 32'hDEAD_BEEF};
        vecs[2] = '{we: 1'b0, addr: 5'd3,  data: 32'h0000_0000, exp: 32'hABBA_DEAD};
        vecs[3] = '{we: 1'b0, addr: 5'd3,  data: 32'h1234_5678, exp: 32'hABBA_DEAD};

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].data;
            @(posedge clk); #1;
            check($sformatf("vec[%0d]", i), rdata, vecs[i].exp);
            if (vecs[i].we) ref_mem[vecs[i].addr] = vecs[i].data;
        end

        // Read-during-write: old contents before the edge, new after
        @(negedge clk);
        we = 1'b1; addr = 5'd5; wdata = 32'hCAFE_F00D;
        #1 check("rdw_before", rdata, 32'h0);
        @(posedge clk); #1;
        check("rdw_after", rdata, 32'hCAFE_F00D);
        ref_mem[5] = 32'hCAFE_F00D;

        // Randomized traffic against the array model
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            we    = ($urandom_range(0, 2) != 0);
            addr  = 5'($urandom_range(0, 31));
            wdata = $urandom;
            #1 check($sformatf("rand_pre[%0d]", n), rdata, ref_mem[addr]);
            @(posedge clk);
            if (we) ref_mem[addr] = wdata;
            #1 check($sformatf("rand_post[%0d]", n), rdata, ref_mem[addr]);
        end

        // Async reset mid-run
        @(negedge clk);
        we = 1'b1; addr = 5'd31; wdata = 32'h5A5A_0001;
        @(posedge clk); #1;
        check("pre_reset_31", rdata, 32'h5A5A_0001);
        #2 rst_n = 1'b0;
        #1 check("async_reset_31", rdata, 32'h0);
        @(negedge clk);
        addr = 5'd7; wdata = 32'h0000_FFFF;
        @(posedge clk); #1;
        check("reset_wins_7", rdata, 32'h0);
        @(negedge clk);
        we = 1'b0;
        rst_n = 1'b1;
        clear_model();
        addr = 5'd3;  #1 check("post_reset_3", rdata, 32'h0);
        addr = 5'd5;  #1 check("post_reset_5", rdata, 32'h0);
        addr = 5'd31; #1 check("post_reset_31", rdata, 32'h0);

        // First posedge after release accepts a write
        we = 1'b1; addr = 5'd9; wdata = 32'h0BAD_CAFE;
        @(posedge clk); #1;
        check("first_write_after_reset", rdata, 32'h0BAD_CAFE);
        ref_mem[9] = 32'h0BAD_CAFE;

        // Final sweep: only addressed words changed
        @(negedge clk);
        we = 1'b0;
        for (int a = 0; a < 32; a++) begin
            addr = a[4:0];
            #1 check($sformatf("final_sweep[%0d]", a), rdata, ref_mem[a]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
